// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one operation in flight, result written straight to the register-file port.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle 33x33 multiply at accept).
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [XLEN-1:0] rd_wdata
);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;   // mul: {hi, lo/multiplier}; div: {remainder, quotient}
    logic                neg_q;   // negate result in FINISH

    logic                accept;
    logic                a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       mul_sum, mul_hi;
    logic [2*XLEN:0]     mul_cat;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_sh, rem_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, result;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
`endif

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign accept   = in_valid & in_ready & ~flush;

    // Operand decode at accept: signedness, magnitudes, result sign and special cases
    always_comb begin
        a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_sgn    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        a_neg    = a_sgn & rs1_rdata[XLEN-1];
        b_neg    = b_sgn & rs2_rdata[XLEN-1];
        a_mag    = a_neg ? -rs1_rdata : rs1_rdata;
        b_mag    = b_neg ? -rs2_rdata : rs2_rdata;
        // Remainder takes the dividend's sign; everything else sign(a)^sign(b)
        neg_in   = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3[2] & (rs2_rdata == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (rs1_rdata == {1'b1, {(XLEN-1){1'b0}}}) &
                   (rs2_rdata == {XLEN{1'b1}});
`ifdef MULDIV_FAST_MUL_EN
        fast_a    = {a_sgn & rs1_rdata[XLEN-1], rs1_rdata};
        fast_b    = {b_sgn & rs2_rdata[XLEN-1], rs2_rdata};
        fast_prod = $signed((2*XLEN)'(fast_a)) * $signed((2*XLEN)'(fast_b));
`endif
    end

    // One radix-2 iteration for multiply and for restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        mul_hi   = acc_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]};
        mul_cat  = {mul_hi, acc_q[XLEN-1:0]};
        mul_next = mul_cat[2*XLEN:1];
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, b_q};
        // Borrow out of the 33-bit subtract means the divisor did not fit
        if (rem_diff[XLEN]) begin
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result select for FINISH
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:              result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:  result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:        result = quo_fix;
            default:           result = rem_fix;
        endcase
    end

    // Control FSM, datapath registers and registered writeback port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rd       <= '0;
            rd_we    <= 1'b0;
            rd_wdata <= '0;
        end else begin
            rd_we <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q  <= funct3;
                        rd_q  <= rd_in;
                        a_q   <= a_mag;
                        b_q   <= b_mag;
                        neg_q <= neg_in;
                        cnt_q <= CNT_W'(XLEN - 1);
                        if (div_zero) begin
                            acc_q   <= {rs1_rdata, {XLEN{1'b1}}};
                            neg_q   <= 1'b0;
                            state_q <= StFinish;
                        end else if (div_ovf) begin
                            acc_q   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                            neg_q   <= 1'b0;
                            state_q <= StFinish;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            acc_q   <= fast_prod;
                            neg_q   <= 1'b0;
                            state_q <= StFinish;
`endif
                        end else begin
                            acc_q   <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        if (cnt_q == '0) begin
                            state_q <= StFinish;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    if (!flush && (rd_q != '0)) begin
                        rd_we    <= 1'b1;
                        rd       <= rd_q;
                        rd_wdata <= result;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard, plus
// reset, flush and rd=0 sequences.
module tb_muldiv_unit;

    localparam int NormLat = 34;
    localparam int SpecLat = 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 34;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_wdata;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1_rdata (rs1_rdata),
        .rs2_rdata (rs2_rdata),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .rd        (rd),
        .rd_we     (rd_we),
        .rd_wdata  (rd_wdata)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdi;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [4:0]  rdi;
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    vec_t vecs[28];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] r,
                                input logic [31:0] e, input int lat, input string name);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rdi = r; v.exp = e; v.lat = lat; v.name = name;
        return v;
    endfunction

    // Scoreboard: every writeback must match the oldest expectation, on its cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rd_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {27'd0, rd}, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, rd_wdata, e.data);
                check({e.name, "_rd"}, {27'd0, rd}, {27'd0, e.rdi});
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    // Drive one request at a negedge; returns #1 after the accepting edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] e, input int lat,
                         input string name, input bit push);
        exp_t x;
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        funct3    = f3;
        rs1_rdata = a;
        rs2_rdata = b;
        rd_in     = r;
        if (push) begin
            x.rdi = r; x.data = e; x.due = cyc + lat; x.name = name;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_drain"}, {31'd0, done}, 32'd1);
        sb.delete();
    endtask

    // Watch for any write over a window; used where no writeback may occur
    task automatic no_write(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen |= rd_we;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; rs1_rdata = '0; rs2_rdata = '0;
        rd_in = '0; flush = 1'b0;

        vecs[0]  = mk(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, MulLat, "mul_m1");
        vecs[1]  = mk(3'd1, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, MulLat, "mulh");
        vecs[2]  = mk(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd7,  32'hFFFFFFFF, MulLat, "mulhsu");
        vecs[3]  = mk(3'd3, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'h00000001, MulLat, "mulhu");
        vecs[4]  = mk(3'd1, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, MulLat, "mulh_min");
        vecs[5]  = mk(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE, MulLat, "mulhu_max");
        vecs[6]  = mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, MulLat, "mulhsu_min");
        vecs[7]  = mk(3'd0, 32'h00000003, 32'hFFFFFFFD, 5'd12, 32'hFFFFFFF7, MulLat, "mul_neg");
        vecs[8]  = mk(3'd0, 32'h00010000, 32'h00010000, 5'd13, 32'h00000000, MulLat, "mul_wrap");
        vecs[9]  = mk(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd14, 32'hFFFFFFFD, NormLat, "div_n7_2");
        vecs[10] = mk(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd15, 32'hFFFFFFFF, NormLat, "rem_n7_2");
        vecs[11] = mk(3'd5, 32'h00000007, 32'h00000002, 5'd16, 32'h00000003, NormLat, "divu_7_2");
        vecs[12] = mk(3'd7, 32'h00000007, 32'h00000002, 5'd17, 32'h00000001, NormLat, "remu_7_2");
        vecs[13] = mk(3'd4, 32'h00000007, 32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, NormLat, "div_7_n2");
        vecs[14] = mk(3'd6, 32'h00000007, 32'hFFFFFFFE, 5'd19, 32'h00000001, NormLat, "rem_7_n2");
        vecs[15] = mk(3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd20, 32'h00000003, NormLat, "div_n7_n2");
        vecs[16] = mk(3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd21, 32'hFFFFFFFF, NormLat, "rem_n7_n2");
        vecs[17] = mk(3'd5, 32'd100,      32'd7,        5'd22, 32'd14,       NormLat, "divu_100_7");
        vecs[18] = mk(3'd7, 32'd100,      32'd7,        5'd23, 32'd2,        NormLat, "remu_100_7");
        vecs[19] = mk(3'd4, 32'h00001234, 32'h00000000, 5'd24, 32'hFFFFFFFF, SpecLat, "div_z");
        vecs[20] = mk(3'd7, 32'h00001234, 32'h00000000, 5'd25, 32'h00001234, SpecLat, "remu_z");
        vecs[21] = mk(3'd5, 32'h00001234, 32'h00000000, 5'd26, 32'hFFFFFFFF, SpecLat, "divu_z");
        vecs[22] = mk(3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd27, 32'hFFFFFFF9, SpecLat, "rem_z");
        vecs[23] = mk(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd28, 32'h80000000, SpecLat, "div_ovf");
        vecs[24] = mk(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd29, 32'h00000000, SpecLat, "rem_ovf");
        vecs[25] = mk(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd30, 32'h00000000, NormLat, "divu_big");
        vecs[26] = mk(3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd31, 32'h80000000, NormLat, "remu_big");
        vecs[27] = mk(3'd5, 32'hFFFFFFFF, 32'h00000001, 5'd1,  32'hFFFFFFFF, NormLat, "divu_by1");

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_we", {31'd0, rd_we}, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_rd_wdata", rd_wdata, 32'd0);
        rst_n = 1'b1;

        // Vector table through the scoreboard
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rdi, vecs[i].exp, vecs[i].lat,
                  vecs[i].name, 1'b1);
            check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
            drain(vecs[i].name);
        end

        // rd_in = 0: executes but never writes
        @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 5'd0, 32'd0, NormLat, "rd0", 1'b0);
        no_write("rd0_no_we", 40);
        check("rd0_idle", {31'd0, busy}, 32'd0);

        // Flush at T+15 of a DIV, then a fresh op accepted at T+16 completes at T+50
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd7, 5'd9, 32'd0, NormLat, "flush_div", 1'b0);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, NormLat, "after_flush", 1'b1);
        drain("after_flush");
        no_write("flush_quiet", 5);

        // Flush in IDLE blocks the accept
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd5; rs1_rdata = 32'd9; rs2_rdata = 32'd3; rd_in = 5'd3;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        no_write("idle_flush_no_we", 40);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd7, 5'd5, 32'd0, NormLat, "rst_mid", 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_we", {31'd0, rd_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_write("rst_mid_no_we", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits directly downstream of the register-file read ports: it consumes rs1_rdata/rs2_rdata and the destination index.
- Its output drives the register-file write port (rd, rd_we, rd_wdata) directly.
- Iterative radix-2 datapath, one operation in flight, valid/ready accept handshake, flush support.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_rdata  input  32  operand a (dividend / multiplicand).
- rs2_rdata  input  32  operand b (divisor / multiplier).
- rd_in  input  5  destination register index.
- flush  input  1  kill in-flight op; no writeback.
- busy  output  1  high in any state other than IDLE.
- rd  output  5  writeback index.
- rd_we  output  1  writeback strobe, one-cycle pulse.
- rd_wdata  output  32  writeback data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, busy=0, rd_we=0, rd=0, rd_wdata=0, counter=0.
- Accept: in_valid & in_ready at rising edge T.
  - Latch funct3, rd_in and both operands.
  - Form operand magnitudes and result sign.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, MUL, DIVU, REMU: unsigned.
  - DIV, REM: both signed.
- Result sign:
  - Products: sign(a)^sign(b), over signed operands only.
  - Quotient: sign(a)^sign(b).
  - Remainder: sign(a).
- States: IDLE -> CALC -> FINISH -> IDLE.
- CALC: exactly 32 cycles (T+1..T+32), counter counts 31 down to 0.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FINISH (cycle T+33): apply sign correction (two's-complement negate), then select:
  - MUL: low 32 bits.
  - MULH*: high 32 bits.
  - DIV*: quotient.
  - REM*: remainder.
  - Register rd_wdata and rd; set rd_we.
- Writeback: rd_we high for exactly one cycle (T+34); state is IDLE and in_ready=1 in that cycle. A new accept is legal at the edge ending T+34.
- Special cases bypass CALC (accept -> FINISH, rd_we at T+2):
  - Divide by zero (b=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- rd_in==0: the op executes normally, but rd_we stays 0 at completion.
- flush:
  - Flush in CALC/FINISH: next state IDLE; no rd_we pulse; rd/rd_wdata hold their previous values.
  - Flush in IDLE: blocks the accept that cycle.
  - Flush coincident with the rd_we cycle: the write still occurs (already committed).
- in_valid while busy: ignored (in_ready=0); the upstream stage must hold the request.
- rd/rd_wdata hold their value between writebacks.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - funct3 0..3 compute a full 33x33 signed product combinationally at accept and go straight to FINISH.
  - Multiply rd_we at T+2; divide ops unchanged (T+34, or T+2 for special cases).
- Undefined: multiplies use the 32-cycle iterative path, rd_we at T+34.

Test Plan:
- Reset mid-CALC (rst_n low at T+10) -> immediately in_ready=1, busy=0, rd_we=0; no write afterwards.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF, rd_in=5 -> rd_we at T+34 (T+2 with macro), rd=5, rd_wdata=0x00000001.
- Products of a=0xFFFFFFFF, b=0x00000002:
  - MULH -> 0xFFFFFFFF.
  - MULHSU -> 0xFFFFFFFF.
  - MULHU -> 0x00000001.
- Signed divide, a=0xFFFFFFF9 (-7), b=2:
  - DIV -> 0xFFFFFFFD (-3), rd_we at T+34.
  - REM -> 0xFFFFFFFF (-1).
  - DIVU, a=7, b=2 -> 3.
- Special cases:
  - DIV a=0x1234, b=0 -> 0xFFFFFFFF at T+2.
  - REMU same operands -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Flush and rd=0 handling:
  - flush at T+15 of a DIV -> no rd_we pulse; in_ready=1 at T+16; a new op accepted at T+16 completes normally at T+50.
  - rd_in=0 op -> rd_we stays 0.
